vga_frame_buffer_ctrl: RTL and testbench

Memory-mapped peripheral between the microprocessor data bus and the VGA signal generator. It holds the 256x128, 1-bit-per-pixel frame buffer as a 32768x1 dual-port RAM. It accepts pixel writes and colour configuration from the bus, runs a hardware clear-screen engine, and serves single-bit reads to the VGA generator with a fixed 1-CLK latency.

---
 rtl/vga_frame_buffer_ctrl.sv | 179 +++++++++++++++++
 tb/tb_vga_frame_buffer_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_buffer_ctrl.sv
// Purpose : bus-mapped 256x128x1 frame buffer with colour registers and a hardware clear engine.
// Latency : VGA_DATA is mem[VGA_ADDR] one CLK later; bus reads are combinational; writes land on the strobe edge.
// Backpress: none; the VGA read port never stalls, and PIXEL writes issued while BUSY are dropped.
//
// Ports:
//   CLK, RESET      system clock, synchronous active-high reset
//   BUS_ADDR/DATA   8-bit register window at BASE_ADDR..BASE_ADDR+5; BUS_DATA driven only on read hits
//   BUS_WE          single-cycle write strobe qualified by BUS_ADDR
//   VGA_ADDR/DATA   {row[6:0], col[7:0]} pixel read port, registered output
//   CONFIG_COLOURS  {foreground, background}
//   BUSY            clear engine running
module vga_frame_buffer_ctrl #(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter logic [7:0] FG_RESET  = 8'hFF,
    parameter logic [7:0] BG_RESET  = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  BUS_ADDR,
    inout  wire  [7:0]  BUS_DATA,
    input  logic        BUS_WE,
    input  logic [14:0] VGA_ADDR,
    output logic        VGA_DATA,
    output logic [15:0] CONFIG_COLOURS,
    output logic        BUSY
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] OFF_X    = 8'd0;
    localparam logic [7:0] OFF_Y    = 8'd1;
    localparam logic [7:0] OFF_PIX  = 8'd2;
    localparam logic [7:0] OFF_FG   = 8'd3;
    localparam logic [7:0] OFF_BG   = 8'd4;
    localparam logic [7:0] OFF_CMD  = 8'd5;
    localparam logic [7:0] WIN_SIZE = 8'd6;

    state_t      state_q, state_d;
    logic [14:0] cnt_q, cnt_d;
    logic        fill_q, fill_d;
    logic [7:0]  x_q;
    logic [6:0]  y_q;
    logic [7:0]  fg_q;
    logic [7:0]  bg_q;
    logic        vga_q;
    logic        mem_q [0:32767];

    logic [7:0]  bus_off;
    logic        in_win;
    logic        wr_x, wr_y, wr_pix, wr_fg, wr_bg, wr_cmd;
    logic        rd_en;
    logic [7:0]  rd_dat;
    logic        ram_we;
    logic [14:0] ram_waddr;
    logic        ram_wdat;

    // Offset arithmetic wraps mod 256, so one compare covers both ends of the window.
    assign bus_off = BUS_ADDR - BASE_ADDR;
    assign in_win  = (bus_off < WIN_SIZE);

    assign wr_x   = BUS_WE && in_win && (bus_off == OFF_X);
    assign wr_y   = BUS_WE && in_win && (bus_off == OFF_Y);
    assign wr_pix = BUS_WE && in_win && (bus_off == OFF_PIX);
    assign wr_fg  = BUS_WE && in_win && (bus_off == OFF_FG);
    assign wr_bg  = BUS_WE && in_win && (bus_off == OFF_BG);
    assign wr_cmd = BUS_WE && in_win && (bus_off == OFF_CMD);

    // Clear engine: next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        case (state_q)
            S_IDLE: begin
                if (wr_cmd && BUS_DATA[0]) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    fill_d  = BUS_DATA[1];
                end
            end
            S_CLEAR: begin
                // Exit on the edge that writes the last address; the counter never wraps on its own.
                if (cnt_q == 15'h7FFF) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 15'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    // Bus-visible registers. X/Y/FG/BG stay writable while the clear runs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q  <= '0;
            y_q  <= '0;
            fg_q <= FG_RESET;
            bg_q <= BG_RESET;
        end else begin
            if (wr_x)  x_q  <= BUS_DATA;
            if (wr_y)  y_q  <= BUS_DATA[6:0];
            if (wr_fg) fg_q <= BUS_DATA;
            if (wr_bg) bg_q <= BUS_DATA;
        end
    end

    // Single RAM write port shared by the clear engine and PIXEL writes; the clear owns it while running.
    // Nothing is written on a reset edge, so a reset mid-clear stops the sweep at once.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdat  = 1'b0;
        if (!RESET) begin
            if (state_q == S_CLEAR) begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdat  = fill_q;
            end else if (wr_pix) begin
                ram_we    = 1'b1;
                ram_waddr = {y_q, x_q};
                ram_wdat  = BUS_DATA[0];
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem_q[ram_waddr] <= ram_wdat;
        end
    end

    // Independent read port: a same-address write on this edge is seen next time (old data now).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vga_q <= 1'b0;
        end else begin
            vga_q <= mem_q[VGA_ADDR];
        end
    end

    // Bus read mux; PIXEL is write-only and is not driven.
    always_comb begin
        rd_dat = 8'h00;
        case (bus_off)
            OFF_X:   rd_dat = x_q;
            OFF_Y:   rd_dat = {1'b0, y_q};
            OFF_FG:  rd_dat = fg_q;
            OFF_BG:  rd_dat = bg_q;
            OFF_CMD: rd_dat = {7'b0, (state_q == S_CLEAR)};
            default: rd_dat = 8'h00;
        endcase
    end

    assign rd_en    = in_win && !BUS_WE && (bus_off != OFF_PIX);
    assign BUS_DATA = rd_en ? rd_dat : 8'hzz;

    assign VGA_DATA       = vga_q;
    assign CONFIG_COLOURS = {fg_q, bg_q};
    assign BUSY           = (state_q == S_CLEAR);

endmodule

// File: tb/tb_vga_frame_buffer_ctrl.sv
module tb_vga_frame_buffer_ctrl;

    localparam logic [7:0] BASE = 8'hB0;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  bus_addr;
    wire  [7:0]  bus_data;
    logic        bus_we;
    logic [14:0] vga_addr;
    logic        vga_data;
    logic [15:0] cfg;
    logic        busy;
    logic        tb_oe;
    logic [7:0]  tb_dat;

    always #10 clk = ~clk;

    assign bus_data = tb_oe ? tb_dat : 8'hzz;

    vga_frame_buffer_ctrl #(
        .BASE_ADDR(BASE),
        .FG_RESET (8'hFF),
        .BG_RESET (8'h00)
    ) dut (
        .CLK           (clk),
        .RESET         (rst),
        .BUS_ADDR      (bus_addr),
        .BUS_DATA      (bus_data),
        .BUS_WE        (bus_we),
        .VGA_ADDR      (vga_addr),
        .VGA_DATA      (vga_data),
        .CONFIG_COLOURS(cfg),
        .BUSY          (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: register file, pixel array and clear status.
    bit         mdl_mem [32768];
    logic [7:0] m_x, m_y, m_fg, m_bg;
    bit         m_busy, m_fill;

    bit   exp_q[$];
    logic vga_req = 1'b0;
    logic req_d   = 1'b0;
    int   busy_run = 0;
    int   busy_len = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: a read issued before a posedge is presented after it.
    always @(posedge clk) req_d <= vga_req;

    always @(negedge clk) begin
        bit e;
        if (req_d) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL vga_unexpected actual=%0d expected=none", vga_data);
            end else begin
                e = exp_q.pop_front();
                chk("vga_data", 32'(vga_data), 32'(e));
            end
        end
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            busy_len = busy_run;
            busy_run = 0;
        end
    end

    function automatic logic [7:0] exp_rd(input int off);
        case (off)
            0: return m_x;
            1: return m_y;
            3: return m_fg;
            4: return m_bg;
            5: return {7'b0, m_busy};
            default: return 8'h00;
        endcase
    endfunction

    // Register-map rules applied to a bus write.
    task automatic model_wr(input logic [7:0] a, input logic [7:0] d);
        if (a >= BASE && a < BASE + 8'd6) begin
            case (int'(a - BASE))
                0: m_x = d;
                1: m_y = {1'b0, d[6:0]};
                2: if (!m_busy) mdl_mem[{m_y[6:0], m_x}] = d[0];
                3: m_fg = d;
                4: m_bg = d;
                5: if (d[0] && !m_busy) begin m_busy = 1'b1; m_fill = d[1]; end
                default: ;
            endcase
        end
    endtask

    // All stimulus tasks start and end at (or just after) a falling edge.
    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a; bus_we = 1'b1; tb_oe = 1'b1; tb_dat = d;
        model_wr(a, d);
        @(negedge clk);
        bus_we = 1'b0; tb_oe = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic rd_chk(input int off, input string nm);
        bus_addr = BASE + 8'(off); bus_we = 1'b0; tb_oe = 1'b0;
        #1;
        chk(nm, 32'(bus_data), 32'(exp_rd(off)));
        @(negedge clk);
        bus_addr = 8'h00;
    endtask

    // The bench drives 0 on the bus; any byte the DUT also drives shows up on top of it.
    task automatic probe(input logic [7:0] a, input string nm);
        bus_addr = a; bus_we = 1'b0; tb_oe = 1'b1; tb_dat = 8'h00;
        #1;
        chk(nm, 32'(bus_data), 32'h0);
        @(negedge clk);
        tb_oe = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic vga_read(input logic [14:0] a);
        vga_addr = a;
        exp_q.push_back(mdl_mem[a]);
        vga_req = 1'b1;
        @(negedge clk);
        vga_req = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        chk({nm, "_done"}, 32'(busy), 32'h0);
        chk({nm, "_len"}, 32'(busy_len), 32'd32768);
        for (int i = 0; i < 32768; i++) mdl_mem[i] = m_fill;
        m_busy = 1'b0;
    endtask

    task automatic model_reset();
        m_x = 8'h00; m_y = 8'h00; m_fg = 8'hFF; m_bg = 8'h00; m_busy = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  xr, yr, dr;
        logic [14:0] ar;
        bit          old;

        rst = 1'b1; bus_addr = 8'h00; bus_we = 1'b0; vga_addr = '0; tb_oe = 1'b0; tb_dat = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_vga", 32'(vga_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cfg", 32'(cfg), 32'hFF00);
        rst = 1'b0;
        @(negedge clk);
        rd_chk(0, "rst_x");
        rd_chk(1, "rst_y");
        rd_chk(5, "rst_status");
        rd_chk(3, "rst_fg");
        rd_chk(4, "rst_bg");

        // Known RAM contents: clear to 0.
        bus_wr(BASE + 8'd5, 8'h01);
        wait_idle("clr0");

        // Directed pixel, back-to-back X/Y/PIXEL writes.
        bus_wr(BASE + 8'd0, 8'h12);
        bus_wr(BASE + 8'd1, 8'hC5);
        bus_wr(BASE + 8'd2, 8'h01);
        vga_read(15'h4512);
        vga_read(15'h4513);
        rd_chk(1, "y_readback");
        chk("y_model", 32'(m_y), 32'h45);

        // Random pixel traffic and random reads.
        repeat (40) begin
            xr = 8'($urandom); yr = 8'($urandom); dr = 8'($urandom);
            bus_wr(BASE + 8'd0, xr);
            bus_wr(BASE + 8'd1, yr);
            bus_wr(BASE + 8'd2, dr);
            vga_read({yr[6:0], xr});
            vga_read(15'($urandom));
        end

        // Read-during-write to the same address returns the old bit.
        bus_wr(BASE + 8'd0, 8'h33);
        bus_wr(BASE + 8'd1, 8'h22);
        old = mdl_mem[15'h2233];
        vga_addr = 15'h2233;
        exp_q.push_back(old);
        vga_req = 1'b1;
        bus_addr = BASE + 8'd2; bus_we = 1'b1; tb_oe = 1'b1; tb_dat = {7'b0, ~old};
        model_wr(BASE + 8'd2, {7'b0, ~old});
        @(negedge clk);
        vga_req = 1'b0; bus_we = 1'b0; tb_oe = 1'b0; bus_addr = 8'h00;
        vga_read(15'h2233);

        // Colour registers.
        repeat (4) begin
            bus_wr(BASE + 8'd3, 8'($urandom));
            bus_wr(BASE + 8'd4, 8'($urandom));
            chk("cfg_rand", 32'(cfg), 32'({m_fg, m_bg}));
            rd_chk(3, "fg_rand");
            rd_chk(4, "bg_rand");
        end
        bus_wr(BASE + 8'd4, 8'h00);

        // Clear with fill 1 and activity during the clear.
        bus_wr(BASE + 8'd5, 8'h03);
        repeat (100) @(negedge clk);
        rd_chk(5, "status_mid");
        bus_wr(BASE + 8'd1, 8'h10);
        bus_wr(BASE + 8'd0, 8'h20);
        bus_wr(BASE + 8'd2, 8'h00);
        bus_wr(BASE + 8'd3, 8'h1C);
        bus_wr(BASE + 8'd5, 8'h01);
        rd_chk(0, "x_during_clear");
        wait_idle("clr1");
        vga_read(15'h0000);
        vga_read(15'h3A7F);
        vga_read(15'h7FFF);
        vga_read(15'h1020);
        chk("cfg_after_clear", 32'(cfg), 32'h1C00);

        // Reset in the middle of a fill-0 clear.
        bus_wr(BASE + 8'd5, 8'h01);
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_cfg", 32'(cfg), 32'hFF00);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 1000; i++) mdl_mem[i] = 1'b0;
        @(negedge clk);
        vga_read(15'd999);
        vga_read(15'd20000);
        vga_read(15'd0);
        rd_chk(0, "x_after_rst");

        // Accesses outside the window change nothing and are never driven.
        bus_wr(BASE + 8'd0, 8'h12);
        bus_wr(BASE + 8'd1, 8'h05);
        bus_wr(BASE + 8'd6, 8'h76);
        bus_wr(8'hA0, 8'h76);
        bus_wr(8'hA2, 8'h76);
        bus_wr(8'hA5, 8'h03);
        chk("oow_busy", 32'(busy), 32'h0);
        rd_chk(0, "oow_x");
        rd_chk(1, "oow_y");
        rd_chk(3, "oow_fg");
        rd_chk(4, "oow_bg");
        vga_read(15'h0512);
        probe(BASE + 8'd6, "float_b6");
        probe(8'hA0, "float_a0");
        probe(8'hA3, "float_a3");

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
